// File: rtl/peak_gen_pkg.sv
`default_nettype none
// ============================================================================
//  peak_gen_pkg
//  Shared types, constants and saturation helper for the peak stimulus source.
//  Rev 1.0
// ============================================================================
package peak_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BASE  = 2'd1,
        PEAK  = 2'd2,
        DECAY = 2'd3
    } state_t;

    localparam int          C_Q_DEFAULT         = 8;
    localparam logic [15:0] C_LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] C_LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic signed [15:0] sat18to16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/peak_stimulus_gen_if.sv
`default_nettype none
// ============================================================================
//  peak_stimulus_gen_if
//  Configuration/control inputs and sample-stream outputs of the generator.
//  Rev 1.0
// ============================================================================
interface peak_stimulus_gen_if;

    logic               start;
    logic               stop;
    logic signed [15:0] baseline;
    logic        [3:0]  noise_shift;
    logic signed [15:0] peak_height;
    logic        [15:0] peak_period;
    logic        [7:0]  peak_width;
    logic        [2:0]  decay_shift;

    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               peak_active;
    logic               busy;
    logic        [15:0] sample_count;

    modport master (
        output start, stop, baseline, noise_shift, peak_height,
               peak_period, peak_width, decay_shift,
        input  sample_out, sample_valid, peak_active, busy, sample_count
    );

    modport slave (
        input  start, stop, baseline, noise_shift, peak_height,
               peak_period, peak_width, decay_shift,
        output sample_out, sample_valid, peak_active, busy, sample_count
    );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  lfsr16
//  16-bit Galois LFSR with synchronous seed reload and advance enable.
//  Rev 1.0
// ============================================================================
module lfsr16
    import peak_gen_pkg::*;
#(
    parameter logic [15:0] SEED = C_LFSR_SEED_DEFAULT,
    parameter logic [15:0] TAPS = C_LFSR_TAPS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= SEED;
        else if (load_i)
            lfsr_q <= SEED;
        else if (adv_i)
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end

    assign state_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/peak_stimulus_gen.sv
`default_nettype none
// ============================================================================
//  peak_stimulus_gen
//  Q8.8 baseline + LFSR noise + hold/decay pulse source, one sample per tick.
//  Rev 1.0
// ============================================================================
module peak_stimulus_gen
    import peak_gen_pkg::*;
#(
    parameter int          Q          = C_Q_DEFAULT,
    parameter int          SAMPLE_DIV = 4,
    parameter logic [15:0] LFSR_SEED  = C_LFSR_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    peak_stimulus_gen_if.slave bus
);

    localparam int               DIV_W      = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] C_DIV_ADV  = DIV_W'(SAMPLE_DIV - 2);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic signed [15:0] baseline_q, height_q, env_q, env_d;
    logic        [3:0]  nshift_q;
    logic        [15:0] period_q, pcnt_q, pcnt_d, idx_q;
    logic        [7:0]  width_q, wcnt_q, wcnt_d;
    logic        [2:0]  dshift_q;

    logic signed [15:0] sample_q;
    logic               valid_q, active_q, busy_q;
    logic        [15:0] count_q;

    logic               w_start, w_tick, w_adv, w_expire, w_dec_done;
    logic        [7:0]  w_width_eff;
    logic signed [15:0] w_dec;
    logic        [15:0] w_lfsr;
    logic signed [Q-1:0] w_nraw, w_nsh;
    logic signed [17:0] w_noise, w_sum;
    logic               w_unused_lfsr;

    assign w_start = bus.start && !bus.stop && (state_q == IDLE);
    assign w_tick  = (state_q != IDLE) && (div_q == C_DIV_LAST);
    // LFSR steps one clock ahead of the tick so the tick sees the advanced value
    assign w_adv   = (state_q != IDLE) && (div_q == C_DIV_ADV);

    lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (C_LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_start),
        .adv_i   (w_adv),
        .state_o (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:Q];
    assign w_nraw        = w_lfsr[Q-1:0];
    assign w_nsh         = w_nraw >>> nshift_q;
    assign w_noise       = (nshift_q == 4'hF) ? 18'sd0 : {{(18-Q){w_nsh[Q-1]}}, w_nsh};

    always_comb begin
        w_width_eff = (width_q == 8'd0) ? 8'd1 : width_q;
        w_expire    = (period_q != 16'd0) && (pcnt_q == period_q);
        pcnt_d      = w_expire ? 16'd1 : pcnt_q + 16'd1;
        w_dec       = env_q >>> dshift_q;
        // -1 is the fixed point of an arithmetic shift on a negative envelope
        w_dec_done  = (w_dec == 16'sd0) || (w_dec == -16'sd1);

        state_d = state_q;
        env_d   = env_q;
        wcnt_d  = wcnt_q;
        if (w_expire) begin
            state_d = PEAK;
            env_d   = height_q;
            wcnt_d  = 8'd1;
        end else if ((state_q == DECAY) ||
                     ((state_q == PEAK) && (wcnt_q >= w_width_eff))) begin
            if (w_dec_done) begin
                state_d = BASE;
                env_d   = 16'sd0;
            end else begin
                state_d = DECAY;
                env_d   = env_q - w_dec;
            end
        end else if (state_q == PEAK) begin
            wcnt_d = wcnt_q + 8'd1;
        end

        w_sum = $signed({{2{baseline_q[15]}}, baseline_q})
              + $signed({{2{env_d[15]}}, env_d})
              + w_noise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            baseline_q <= '0;
            height_q   <= '0;
            env_q      <= '0;
            nshift_q   <= '0;
            period_q   <= '0;
            pcnt_q     <= '0;
            idx_q      <= '0;
            width_q    <= '0;
            wcnt_q     <= '0;
            dshift_q   <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            div_q   <= '0;
        end else if (w_start) begin
            state_q    <= BASE;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
            div_q      <= '0;
            idx_q      <= '0;
            env_q      <= '0;
            pcnt_q     <= '0;
            wcnt_q     <= '0;
            baseline_q <= bus.baseline;
            nshift_q   <= bus.noise_shift;
            height_q   <= bus.peak_height;
            period_q   <= bus.peak_period;
            width_q    <= bus.peak_width;
            dshift_q   <= bus.decay_shift;
        end else begin
            valid_q <= 1'b0;
            if (state_q != IDLE)
                div_q <= w_tick ? '0 : div_q + DIV_W'(1);
            if (w_tick) begin
                state_q  <= state_d;
                env_q    <= env_d;
                wcnt_q   <= wcnt_d;
                pcnt_q   <= pcnt_d;
                idx_q    <= idx_q + 16'd1;
                count_q  <= idx_q;
                sample_q <= sat18to16(w_sum);
                active_q <= (env_d != 16'sd0);
                valid_q  <= 1'b1;
            end
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.peak_active  = active_q;
    assign bus.busy         = busy_q;
    assign bus.sample_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_peak_stimulus_gen.sv
`default_nettype none
// ============================================================================
//  tb_peak_stimulus_gen
//  Directed scoreboard bench: expected samples queued at stimulus, popped on strobe.
//  Rev 1.0
// ============================================================================
module tb_peak_stimulus_gen;

    localparam int C_DIV = 4;

    typedef struct {
        logic [15:0] val;
        logic [15:0] idx;
        logic        act;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];
    exp_t mon_e;

    peak_stimulus_gen_if bus ();

    peak_stimulus_gen #(
        .SAMPLE_DIV (C_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("stray_strobe", {15'd0, bus.sample_valid}, 16'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sample_out",   bus.sample_out,   mon_e.val);
                check("sample_count", bus.sample_count, mon_e.idx);
                check("peak_active",  {15'd0, bus.peak_active}, {15'd0, mon_e.act});
            end
        end
    end

    function automatic logic [15:0] shape(int i, int per, int wid);
        int k;
        if (per == 0 || i < per) return 16'h0000;
        k = i % per;
        if (k < wid) return 16'h0800;
        return 16'h0800 >> (k - wid + 1);
    endfunction

    function automatic logic [15:0] lfsr_step(logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] noise_of(logic [15:0] l, int sh);
        logic signed [15:0] n;
        n = $signed(l[7:0]);
        return n >>> sh;
    endfunction

    task automatic push(input logic [15:0] val, input int idx, input logic act);
        exp_t e;
        e.val = val;
        e.idx = 16'(idx);
        e.act = act;
        exp_q.push_back(e);
    endtask

    task automatic start_gen(input logic [15:0] base, input logic [3:0] ns,
                             input logic [15:0] h, input logic [15:0] p,
                             input logic [7:0] w, input logic [2:0] ds);
        @(negedge clk);
        bus.baseline    = base;
        bus.noise_shift = ns;
        bus.peak_height = h;
        bus.peak_period = p;
        bus.peak_width  = w;
        bus.decay_shift = ds;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 16'(exp_q.size()), 16'd0);
            exp_q.delete();
        end
    endtask

    task automatic stop_gen();
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        check("busy_after_stop",  {15'd0, bus.busy},         16'd0);
        check("valid_after_stop", {15'd0, bus.sample_valid}, 16'd0);
    endtask

    task automatic idle_watch(input int cycles);
        repeat (cycles) @(negedge clk);
        check("busy_idle", {15'd0, bus.busy}, 16'd0);
    endtask

    initial begin
        logic [15:0] l;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.baseline = '0; bus.noise_shift = '0; bus.peak_height = '0;
        bus.peak_period = '0; bus.peak_width = '0; bus.decay_shift = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample_out",   bus.sample_out,               16'd0);
        check("rst_sample_valid", {15'd0, bus.sample_valid},    16'd0);
        check("rst_peak_active",  {15'd0, bus.peak_active},     16'd0);
        check("rst_busy",         {15'd0, bus.busy},            16'd0);
        check("rst_sample_count", bus.sample_count,             16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch(5 * C_DIV);

        // Flat baseline with first-strobe timing
        for (int i = 0; i < 8; i++) push(16'h0100, i, 1'b0);
        start_gen(16'h0100, 4'hF, 16'h0800, 16'd0, 8'd0, 3'd0);
        check("busy_after_start", {15'd0, bus.busy}, 16'd1);
        for (int i = 1; i <= C_DIV; i++) begin
            @(posedge clk);
            #1;
            check("first_valid_timing", {15'd0, bus.sample_valid}, (i == C_DIV) ? 16'd1 : 16'd0);
        end
        drain(12 * C_DIV);
        stop_gen();
        check("hold_count_after_stop", bus.sample_count, 16'd7);
        idle_watch(3 * C_DIV);

        // Peak shape: hold two samples, halve to 1, then baseline, repeat at 60
        for (int i = 0; i < 63; i++) begin
            l = shape(i, 30, 2);
            push(l, i, l != 16'h0000);
        end
        start_gen(16'h0000, 4'hF, 16'h0800, 16'd30, 8'd2, 3'd1);
        drain(70 * C_DIV);
        stop_gen();
        idle_watch(2 * C_DIV);

        // Retrigger; config edits while busy are ignored
        for (int i = 0; i < 21; i++) begin
            l = shape(i, 5, 4);
            push(l, i, l != 16'h0000);
        end
        start_gen(16'h0000, 4'hF, 16'h0800, 16'd5, 8'd4, 3'd1);
        bus.baseline    = 16'h1234;
        bus.peak_period = 16'd3;
        bus.noise_shift = 4'h0;
        drain(25 * C_DIV);
        stop_gen();
        idle_watch(2 * C_DIV);

        // Saturation at the positive rail
        for (int i = 0; i < 9; i++)
            push((i < 3) ? 16'h7000 : 16'h7FFF, i, i >= 3);
        start_gen(16'h7000, 4'hF, 16'h2000, 16'd3, 8'd1, 3'd3);
        drain(12 * C_DIV);
        stop_gen();
        idle_watch(2 * C_DIV);

        // Noise: two starts reproduce the seeded sequence, then attenuated noise
        for (int run = 0; run < 3; run++) begin
            l = 16'hACE1;
            for (int i = 0; i < 10; i++) begin
                l = lfsr_step(l);
                push(noise_of(l, (run == 2) ? 2 : 0), i, 1'b0);
            end
            start_gen(16'h0000, (run == 2) ? 4'h2 : 4'h0, 16'h0000, 16'd0, 8'd0, 3'd0);
            drain(14 * C_DIV);
            stop_gen();
            idle_watch(C_DIV);
        end

        // Stop at index 7 while in PEAK: outputs hold, no further strobes
        for (int i = 0; i < 8; i++) begin
            l = shape(i, 5, 4);
            push(l, i, l != 16'h0000);
        end
        start_gen(16'h0000, 4'hF, 16'h0800, 16'd5, 8'd4, 3'd1);
        drain(12 * C_DIV);
        stop_gen();
        check("hold_sample_out",  bus.sample_out,           16'h0800);
        check("hold_peak_active", {15'd0, bus.peak_active}, 16'd1);
        check("hold_count",       bus.sample_count,         16'd7);
        idle_watch(3 * C_DIV);

        // Simultaneous start and stop in IDLE stays IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_busy", {15'd0, bus.busy}, 16'd0);
        idle_watch(3 * C_DIV);

        // Asynchronous reset mid-run clears outputs immediately
        push(16'h0100, 0, 1'b0);
        push(16'h0100, 1, 1'b0);
        start_gen(16'h0100, 4'hF, 16'h0000, 16'd0, 8'd0, 3'd0);
        drain(6 * C_DIV);
        rst_n = 1'b0;
        #1;
        check("midrst_sample_out",   bus.sample_out,            16'd0);
        check("midrst_sample_count", bus.sample_count,          16'd0);
        check("midrst_busy",         {15'd0, bus.busy},         16'd0);
        check("midrst_valid",        {15'd0, bus.sample_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch(4 * C_DIV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, vectors %0d miscompares %0d", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
